// File: rtl/ez8_cpu.sv
// rtl/ez8_cpu.sv - ez8 8-bit accumulator core with 4096x16 instruction memory and 2-stage pipeline
module ez8_cpu (
    input  logic        clk,
    input  logic        reset,
    input  logic        pause,
    input  logic [11:0] instr_writeaddr,
    input  logic [15:0] instr_writedata,
    input  logic        instr_write_en,
    output logic [7:0]  accum_out
);

    logic [15:0] imem [0:4095];
    logic [7:0]  regs [0:15];

    logic [11:0] pc;
    logic [15:0] ir;
    logic        ir_valid;
    logic [7:0]  acc;

    logic [3:0]  op;
    logic [3:0]  rsel;
    logic [7:0]  imm;
    logic [7:0]  rval;
    logic        taken;

    assign op    = ir[15:12];
    assign rsel  = ir[11:8];
    assign imm   = ir[7:0];
    assign rval  = regs[rsel];
    assign accum_out = acc;

    always_comb begin
        taken = 1'b0;
        if (ir_valid) begin
            case (op)
                4'hA:    taken = 1'b1;
                4'hB:    taken = (acc == 8'h00);
                4'hC:    taken = (acc != 8'h00);
                default: taken = 1'b0;
            endcase
        end
    end

    // Write port ignores reset and pause so programs can be loaded while the core is held.
    always_ff @(posedge clk) begin
        if (instr_write_en)
            imem[instr_writeaddr] <= instr_writedata;
    end

    // Execute reads regs directly; STA->LDA back-to-back sees the new value since each
    // instruction retires on its own edge before the next one executes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc       <= 12'h000;
            ir       <= 16'h0000;
            ir_valid <= 1'b0;
            acc      <= 8'h00;
            for (int i = 0; i < 16; i++)
                regs[i] <= 8'h00;
        end else if (!pause) begin
            if (taken) begin
                pc       <= ir[11:0];
                ir_valid <= 1'b0;
            end else begin
                ir       <= imem[pc];
                ir_valid <= 1'b1;
                pc       <= pc + 12'd1;
            end
            if (ir_valid) begin
                case (op)
                    4'h0:    acc <= acc + imm;
                    4'h1:    acc <= acc - imm;
                    4'h2:    regs[rsel] <= acc;
                    4'h3:    acc <= rval;
                    4'h4:    acc <= imm;
                    4'h5:    acc <= acc + rval;
                    4'h6:    acc <= {7'd0, (rval < imm)};
                    4'h7:    acc <= acc & imm;
                    4'h8:    acc <= acc | imm;
                    4'h9:    acc <= acc ^ imm;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ez8_cpu.sv
// tb/tb_ez8_cpu.sv - self-checking bench for ez8_cpu against an instruction-level model
module tb_ez8_cpu;

    logic        clk = 1'b0;
    logic        reset;
    logic        pause;
    logic [11:0] instr_writeaddr;
    logic [15:0] instr_writedata;
    logic        instr_write_en;
    logic [7:0]  accum_out;

    int nchk = 0;
    int nerr = 0;
    bit cmp_en = 1'b0;

    ez8_cpu dut (
        .clk             (clk),
        .reset           (reset),
        .pause           (pause),
        .instr_writeaddr (instr_writeaddr),
        .instr_writedata (instr_writedata),
        .instr_write_en  (instr_write_en),
        .accum_out       (accum_out)
    );

    always #5 clk = ~clk;

    // Instruction-level model: one instruction per unpaused cycle, one bubble after
    // reset release and after every taken jump.
    bit   [15:0] m_mem [4096];
    logic [7:0]  m_reg [16];
    logic [7:0]  m_acc;
    int          m_pc;
    int          m_bub;

    task automatic model_reset();
        m_acc = 8'h00;
        m_pc  = 0;
        m_bub = 1;
        for (int i = 0; i < 16; i++) m_reg[i] = 8'h00;
    endtask

    initial model_reset();

    always @(posedge clk) begin
        if (!reset) begin
            model_reset();
        end else if (!pause) begin
            if (m_bub > 0) begin
                m_bub = m_bub - 1;
            end else begin
                logic [15:0] w;
                logic [3:0]  o;
                logic [3:0]  r;
                logic [7:0]  k;
                bit          jmp;
                w = m_mem[m_pc];
                o = w[15:12];
                r = w[11:8];
                k = w[7:0];
                jmp = 1'b0;
                case (o)
                    4'd0:  m_acc = m_acc + k;
                    4'd1:  m_acc = m_acc - k;
                    4'd2:  m_reg[r] = m_acc;
                    4'd3:  m_acc = m_reg[r];
                    4'd4:  m_acc = k;
                    4'd5:  m_acc = m_acc + m_reg[r];
                    4'd6:  m_acc = (m_reg[r] < k) ? 8'd1 : 8'd0;
                    4'd7:  m_acc = m_acc & k;
                    4'd8:  m_acc = m_acc | k;
                    4'd9:  m_acc = m_acc ^ k;
                    4'd10: jmp = 1'b1;
                    4'd11: jmp = (m_acc == 8'd0);
                    4'd12: jmp = (m_acc != 8'd0);
                    default: ;
                endcase
                if (jmp) begin
                    m_pc  = int'(w[11:0]);
                    m_bub = 1;
                end else begin
                    m_pc = (m_pc + 1) % 4096;
                end
            end
        end
        if (instr_write_en) m_mem[instr_writeaddr] = instr_writedata;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [7:0] exp_acc;
            exp_acc = reset ? m_acc : 8'h00;
            nchk++;
            if (accum_out !== exp_acc) begin
                nerr++;
                $display("FAIL acc_cycle t=%0t: got %h expected %h", $time, accum_out, exp_acc);
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] exp_v);
        nchk++;
        if (accum_out !== exp_v) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, accum_out, exp_v);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    logic [15:0] prog [32];

    task automatic load_prog();
        reset = 1'b0;
        pause = 1'b1;
        for (int a = 0; a < 32; a++) begin
            instr_write_en  = 1'b1;
            instr_writeaddr = 12'(a);
            instr_writedata = prog[a];
            run(1);
        end
        instr_write_en = 1'b0;
        run(1);
    endtask

    task automatic clear_prog();
        for (int a = 0; a < 32; a++) prog[a] = 16'h0000;
    endtask

    task automatic go();
        reset = 1'b1;
        pause = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        pause = 1'b1;
        instr_write_en  = 1'b0;
        instr_writeaddr = 12'h000;
        instr_writedata = 16'h0000;
        #1;
        for (int a = 0; a < 4096; a++) begin
            instr_write_en  = 1'b1;
            instr_writeaddr = 12'(a);
            instr_writedata = 16'h0000;
            run(1);
        end
        instr_write_en = 1'b0;
        run(1);
        chk("reset_acc", 8'h00);
        cmp_en = 1'b1;

        // LDI 0x50; ADDI 1; LDI 0; STA r1; SLTI r1,0x48 -> 1
        clear_prog();
        prog[0] = 16'h4050; prog[1] = 16'h0101; prog[2] = 16'h4100;
        prog[3] = 16'h2100; prog[4] = 16'h6148;
        load_prog();
        go();
        run(8);
        pause = 1'b1;
        chk("plan1_acc", 8'h01);
        for (int i = 0; i < 3; i++) begin
            run(1);
            chk("plan1_paused", 8'h01);
        end

        clear_prog();
        prog[0] = 16'h40FF; prog[1] = 16'h0002;
        load_prog();
        go();
        run(2);
        chk("ldi_ff", 8'hFF);
        run(1);
        chk("addi_wrap", 8'h01);

        clear_prog();
        prog[0] = 16'h4005; prog[1] = 16'h2300; prog[2] = 16'h4000; prog[3] = 16'h5300;
        load_prog();
        go();
        run(5);
        chk("sta_add_bypass", 8'h05);

        clear_prog();
        prog[0] = 16'h4000; prog[1] = 16'hB010; prog[2] = 16'h4077; prog[16] = 16'h4022;
        load_prog();
        go();
        for (int i = 0; i < 10; i++) begin
            run(1);
            nchk++;
            if (accum_out === 8'h77) begin
                nerr++;
                $display("FAIL bz_squash: got %h expected not 77", accum_out);
            end
        end
        chk("bz_target", 8'h22);

        clear_prog();
        prog[0] = 16'h4001;
        for (int a = 1; a < 32; a++) prog[a] = 16'h0001;
        load_prog();
        go();
        run(6);
        chk("inc_before_pause", 8'h05);
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run(1);
            chk("inc_frozen", 8'h05);
        end
        pause = 1'b0;
        for (int i = 0; i < 4; i++) begin
            run(1);
            chk("inc_resume", 8'(6 + i));
        end

        #1;
        reset = 1'b0;
        #1;
        chk("async_reset", 8'h00);
        run(1);
        reset = 1'b1;
        run(2);
        chk("rerun_first", 8'h01);
        run(1);
        chk("rerun_second", 8'h02);

        for (int p = 0; p < 8; p++) begin
            for (int a = 0; a < 32; a++) begin
                logic [3:0] o;
                o = 4'($urandom_range(0, 15));
                if (o >= 4'hA && o <= 4'hC)
                    prog[a] = {o, 12'($urandom_range(0, 31))};
                else
                    prog[a] = {o, 12'($urandom)};
            end
            load_prog();
            go();
            for (int c = 0; c < 200; c++) begin
                pause = ($urandom_range(0, 3) == 0);
                reset = ($urandom_range(0, 99) != 0);
                run(1);
            end
        end

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/ez8_cpu.md
# ez8_cpu

8-bit accumulator processor core with on-chip 4096×16 instruction memory, a 16×8 register file and a two-stage fetch/execute pipeline. Instruction memory is loaded through a write port, normally while the core is paused. The accumulator is exported for observation. It is the top of the ez8 processor, instantiated by the system/bench that loads programs.

## Interface
- No parameters. Fixed widths: 12-bit PC, 16-bit instruction, 8-bit data.
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low; clears PC, pipeline, accumulator, register file.
- pause  in  1  high = freeze PC, pipeline, accumulator, registers.
- instr_writeaddr  in  12  instruction-memory write address.
- instr_writedata  in  16  instruction word to write.
- instr_write_en  in  1  write strobe; writes on the rising edge, independent of pause and reset.
- accum_out  out  8  current accumulator value, registered.

## Operation
- Instruction format: [15:12] opcode, [11:8] r (register index), [7:0] imm; jumps use [11:0] as target.
- Opcodes:
  - 0 ADDI: acc += imm.
  - 1 SUBI: acc -= imm.
  - 2 STA: reg[r] = acc.
  - 3 LDA: acc = reg[r].
  - 4 LDI: acc = imm.
  - 5 ADD: acc += reg[r].
  - 6 SLTI: acc = (reg[r] < imm, unsigned) ? 1 : 0.
  - 7 ANDI: acc &= imm.
  - 8 ORI: acc |= imm.
  - 9 XORI: acc ^= imm.
  - A JMP: PC = [11:0].
  - B BZ: jump if acc==0.
  - C BNZ: jump if acc!=0.
  - D–F: NOP.
- The r field is ignored by opcodes 0, 1, 4, 7, 8, 9.
- Arithmetic is 8-bit, modulo 256; no flags are stored.
- Instruction memory initialises to all zero at configuration (0x0000 = ADDI 0, effectively a NOP).
- Memory is not cleared by reset.
- Register file and accumulator reset to 0.
- PC increments modulo 4096: 0xFFF wraps to 0x000.

## Timing
- During reset: PC=0, fetch stage invalid, acc=0, accum_out=0, all regs=0.
- Stage 1 (fetch): synchronous memory read at PC; PC advances by 1.
- Stage 2 (execute): the fetched word updates acc, regs, or PC.
- Reset release: first cycle fetches address 0 (execute stage holds a bubble).
  - Instruction k completes on edge k+2 after reset deasserts, with pause low.
- accum_out reflects a result from the edge on which the instruction executes.
- Taken jump/branch: the instruction already fetched is squashed (1-cycle bubble); fetch resumes at the target on the next edge.
- STA followed immediately by LDA/ADD/SLTI of the same register reads the new value (bypass required).
- pause high: no state except instruction memory changes; accum_out holds.
  - Deasserting pause resumes exactly where execution stopped; no instruction is lost or duplicated.
- Write port: a write and a fetch of the same address in the same cycle fetch the old word.
- Reset asserted mid-program: immediate asynchronous return to the reset state; memory contents are preserved.
- Reset has priority over pause.

## Test plan
- Load 0x4050, 0x0101, 0x4100, 0x2100, 0x6148 at 0–4 while paused. Release reset, run 8 cycles, pause. Required: accum_out==0x01, and it stays 0x01 for the 3 paused cycles.
- Load LDI 0xFF; ADDI 0x02. Run. Required: acc 0xFF, then 0x01 (wrap).
- Program LDI 5; STA r3; LDI 0; ADD r3. Required: acc==5 (bypass).
- Program LDI 0; BZ 0x010; LDI 0x77 at address 2; LDI 0x22 at 0x010. Required: acc never equals 0x77; final acc 0x22.
- Program LDI 1; ADDI 1 repeated. Hold pause high for 5 cycles mid-run. Required: acc frozen while paused; then continues incrementing by 1 per cycle with no skipped value.
- Assert reset mid-run. Required: accum_out=0 immediately (asynchronous). After release, the program reruns from address 0 with the same results.
